// File: rtl/axi_resp_pkg.sv
// Shared types and default widths for the AXI memory read responder and its request queue.
package axi_resp_pkg;

  localparam int unsigned REQ_ADDR_BITS            = 64;
  localparam int unsigned REQ_BURST_LEN_WIDTH      = 8;
  localparam int unsigned REQ_TID_WIDTH            = 8;
  localparam int unsigned REQ_LOG_BLOCK_DATA_BYTES = 0;

  function automatic int unsigned data_width(input int unsigned log_block_data_bytes);
    return (32'd1 << log_block_data_bytes) * 32'd8;
  endfunction

  localparam int unsigned REQ_DATA_WIDTH = data_width(REQ_LOG_BLOCK_DATA_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_e;

  typedef struct packed {
    logic [REQ_ADDR_BITS-1:0]       addr;
    logic [REQ_BURST_LEN_WIDTH-1:0] len;
    logic [REQ_TID_WIDTH-1:0]       id;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO of request entries with full/empty/occupancy status.
module req_fifo
  import axi_resp_pkg::*;
#(
  parameter type         entry_t   = req_t,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               push,
  input  entry_t             push_data,
  input  logic               pop,
  output entry_t             pop_data,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);

  localparam int unsigned          DEPTH    = 32'd1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_FULL = (LOG_DEPTH + 1)'(DEPTH);

  entry_t               mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]   count_q;
  logic                 push_ok, pop_ok;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  // Storage needs no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_mem_read_responder.sv
// Memory-side AXI read responder: queues AR requests in order, waits a programmable
// latency, then returns len+1 R beats whose data is the low bits of the beat address.
module axi_mem_read_responder
  import axi_resp_pkg::*;
#(
  parameter int unsigned ADDR_BITS            = REQ_ADDR_BITS,
  parameter int unsigned BURST_LEN_WIDTH      = REQ_BURST_LEN_WIDTH,
  parameter int unsigned TID_WIDTH            = REQ_TID_WIDTH,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = REQ_LOG_BLOCK_DATA_BYTES,
  parameter int unsigned LOG_QUEUE_SIZE       = 3,
  parameter int unsigned LATENCY_WIDTH        = 8
) (
  input  logic                                         clk,
  input  logic                                         resetN,
  input  logic                                         en,
  input  logic [LATENCY_WIDTH-1:0]                     cfg_latency,
  input  logic                                         ar_valid,
  output logic                                         ar_ready,
  input  logic [ADDR_BITS-1:0]                         ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]                   ar_len,
  input  logic [TID_WIDTH-1:0]                         ar_id,
  output logic                                         r_valid,
  input  logic                                         r_ready,
  output logic                                         r_last,
  output logic [data_width(LOG_BLOCK_DATA_BYTES)-1:0]  r_data,
  output logic [TID_WIDTH-1:0]                         r_id,
  output logic [LOG_QUEUE_SIZE:0]                      outstanding
);

  localparam int unsigned                DATA_WIDTH  = data_width(LOG_BLOCK_DATA_BYTES);
  localparam int unsigned                OCC_WIDTH   = LOG_QUEUE_SIZE + 1;
  localparam logic [LATENCY_WIDTH-1:0]   LAT_ONE     = LATENCY_WIDTH'(1);
  localparam logic [BURST_LEN_WIDTH-1:0] BEAT_ONE    = BURST_LEN_WIDTH'(1);
  localparam logic [ADDR_BITS-1:0]       BEAT_STRIDE = ADDR_BITS'(1) << LOG_BLOCK_DATA_BYTES;

  state_e                     state_q, state_d;
  logic                       live_q;
  logic [LATENCY_WIDTH-1:0]   cnt_q;
  logic [BURST_LEN_WIDTH-1:0] beat_q, len_q;
  logic [TID_WIDTH-1:0]       id_q;
  logic [ADDR_BITS-1:0]       beat_addr_q;
  logic                       last_q;
  logic [OCC_WIDTH-1:0]       outstanding_q, occ_d, fifo_count;
  logic                       push, load, advance;
  logic                       fifo_full, fifo_empty;
  req_t                       push_req, head_req;

  // live_q keeps ar_ready low while reset is asserted and for the first edge after release.
  assign ar_ready = en & live_q & ~fifo_full;
  assign push     = ar_valid & ar_ready;
  assign push_req = '{addr: ar_addr, len: ar_len, id: ar_id};

  req_fifo #(
    .entry_t   (req_t),
    .LOG_DEPTH (LOG_QUEUE_SIZE)
  ) u_req_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (push),
    .push_data (push_req),
    .pop       (load),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (load) state_d = (cfg_latency == '0) ? BURST : WAIT;
      WAIT:  if (en && cnt_q == LAT_ONE) state_d = BURST;
      BURST: begin
        if (r_ready && last_q) begin
          if (load) state_d = (cfg_latency == '0) ? BURST : WAIT;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine load pops the queue head; advance steps to the next beat of the current burst.
  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE:  load = en & ~fifo_empty;
      BURST: begin
        load    = r_ready & last_q & en & ~fifo_empty;
        advance = r_ready & ~last_q;
      end
      default: ;
    endcase
  end

  assign occ_d = fifo_count + OCC_WIDTH'(push) - OCC_WIDTH'(load);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      live_q        <= 1'b0;
      cnt_q         <= '0;
      beat_q        <= '0;
      len_q         <= '0;
      id_q          <= '0;
      beat_addr_q   <= '0;
      last_q        <= 1'b0;
      outstanding_q <= '0;
    end else begin
      live_q <= 1'b1;
      if (load) begin
        cnt_q       <= cfg_latency;
        beat_q      <= '0;
        len_q       <= head_req.len;
        id_q        <= head_req.id;
        beat_addr_q <= head_req.addr;
        last_q      <= (head_req.len == '0);
      end else if (advance) begin
        beat_q      <= beat_q + BEAT_ONE;
        beat_addr_q <= beat_addr_q + BEAT_STRIDE;
        last_q      <= ((beat_q + BEAT_ONE) == len_q);
      end else if (state_q == WAIT && en) begin
        cnt_q <= cnt_q - LAT_ONE;
      end
      outstanding_q <= occ_d + OCC_WIDTH'(state_d != IDLE);
    end
  end

  assign r_valid     = (state_q == BURST);
  assign r_last      = r_valid & last_q;
  assign r_data      = beat_addr_q[DATA_WIDTH-1:0];
  assign r_id        = id_q;
  assign outstanding = outstanding_q;

endmodule
